// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and constants for the tri-state bus arbiter: FSM state encoding
// and width helpers used to size indices and counters.
package tristate_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result = 0;
    int rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // A zero-width vector is illegal, so small counts still get one bit.
  function automatic int width_of(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant bundle between the requesting agents, the arbiter and the
// bank of tri-state buffers it enables.
interface tristate_bus_arbiter_if
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N = 4
);
  localparam int IW = width_of(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  en;
  logic [IW-1:0] owner;
  logic          busy;

  modport master (input req, output gnt, output en, output owner, output busy);
  modport slave  (output req, input gnt, input en, input owner, input busy);
endinterface

// File: rtl/tristate_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: rotates req so ptr sits at bit 0, finds the
// first set bit, then rotates the index back into requester numbering.
module rr_priority_picker
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = width_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] rotated;
  int           first;
  int           pos;

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    rotated = N'({req, req} >> ptr);
    any     = |req;
    first   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) first = k;
    end
    pos = first + int'(ptr);
    if (pos >= N) pos = pos - N;
    idx    = any ? IW'(pos) : '0;
    onehot = any ? (N'(1) << pos) : '0;
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus segment, with a bounded
// tenure and a dead turnaround gap (all enables low) between owners.
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 8
) (
  input logic                   clk,
  input logic                   rst,
  tristate_bus_arbiter_if.master bus
);

  localparam int IW = width_of(N);
  localparam int HW = width_of(MAX_HOLD + 1);
  localparam int TW = width_of(TURN_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  state_t        state;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_ptr;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] turn_cnt;
  logic          busy_q;

  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_priority_picker #(.N(N)) u_picker (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  logic hold_expired;
  logic turn_done;
  logic may_start;

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign turn_done    = (state == ST_TURN) && (turn_cnt == TURN_LAST);
  assign may_start    = (state == ST_IDLE) || turn_done;

  // NOTE: state is updated only with non-blocking assignments, so every branch
  // below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      busy_q   <= 1'b0;
    end else if (may_start && pick_any) begin
      state    <= ST_GRANT;
      gnt_q    <= pick_onehot;
      owner_q  <= pick_idx;
      hold_cnt <= '0;
      busy_q   <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: busy_q <= 1'b0;
        ST_GRANT: begin
          if (!bus.req[owner_q] || hold_expired) begin
            state    <= ST_TURN;
            gnt_q    <= '0;
            rr_ptr   <= (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
            turn_cnt <= '0;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_TURN: begin
          // The last dead cycle with nobody requesting falls back to idle.
          if (turn_done) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Buffer enables are the grant register itself, so they can never disagree.
  assign bus.gnt   = gnt_q;
  assign bus.en    = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

endmodule
